// File: rtl/debug_disp_pkg.sv
// Shared definitions for the debug probe display path: glyph constants,
// segment bit order and the channel scan mode.
package debug_disp_pkg;

    // seg = {dp, g, f, e, d, c, b, a}, active-high
    localparam int SEG_DP_BIT = 7;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } scan_mode_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to seven-segment glyph decode, bit order {g,f,e,d,c,b,a}.
module hex_to_seg7
    import debug_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = SEG_BLANK;
        case (nibble_i)
            4'h0: glyph_o = SEG_0;
            4'h1: glyph_o = SEG_1;
            4'h2: glyph_o = SEG_2;
            4'h3: glyph_o = SEG_3;
            4'h4: glyph_o = SEG_4;
            4'h5: glyph_o = SEG_5;
            4'h6: glyph_o = SEG_6;
            4'h7: glyph_o = SEG_7;
            4'h8: glyph_o = SEG_8;
            4'h9: glyph_o = SEG_9;
            4'hA: glyph_o = SEG_A;
            4'hB: glyph_o = SEG_B;
            4'hC: glyph_o = SEG_C;
            4'hD: glyph_o = SEG_D;
            4'hE: glyph_o = SEG_E;
            4'hF: glyph_o = SEG_F;
            default: glyph_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/debug_probe_display.sv
// Debug probe: selects one of NCH CPU signals (manual or auto-scan), snapshots it
// once per frame and scans it onto the hex display. DEBUG_PROBE_ZERO_BLANK_EN blanks leading zeros.
//
// state       | meaning
// MODE_MANUAL | channel comes from sel (out-of-range -> 0)
// MODE_AUTO   | channel advances every DWELL_FRAMES frames
module debug_probe_display
    import debug_disp_pkg::*;
#(
    parameter int NCH          = 16,
    parameter int DW           = 32,
    parameter int DIGITS       = 8,
    parameter int REFRESH_DIV  = 50000,
    parameter int DWELL_FRAMES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] probe_bus,
    input  logic [3:0]        sel,
    input  logic              auto_en,
    input  logic              freeze,
    output logic [3:0]        cur_ch,
    output logic              sel_err,
    output logic [3:0]        which,
    output logic [7:0]        seg
);

    localparam int DCW = $clog2(REFRESH_DIV);
    localparam int FCW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [DCW-1:0] DIV_LAST   = DCW'(REFRESH_DIV - 1);
    localparam logic [FCW-1:0] DWELL_LAST = FCW'(DWELL_FRAMES - 1);
    localparam logic [3:0]     DIG_LAST   = 4'(DIGITS - 1);
    localparam logic [3:0]     CH_LAST    = 4'(NCH - 1);

    scan_mode_e     mode_q, mode_d;
    logic [DCW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]     which_q, which_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]     cur_ch_q, cur_ch_d;
    logic [DW-1:0]  snap_q, snap_d;
    logic           sel_err_q, sel_err_d;

    logic           digit_tick, frame_tick, sel_oor, blank, dp;
    logic [3:0]     next_ch, nibble;
    logic [6:0]     glyph;
    logic [DW-1:0]  ch_data [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign ch_data[k] = probe_bus[k*DW +: DW];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q      <= MODE_MANUAL;
            div_cnt_q   <= '0;
            which_q     <= '0;
            frame_cnt_q <= '0;
            cur_ch_q    <= '0;
            snap_q      <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            div_cnt_q   <= div_cnt_d;
            which_q     <= which_d;
            frame_cnt_q <= frame_cnt_d;
            cur_ch_q    <= cur_ch_d;
            snap_q      <= snap_d;
            sel_err_q   <= sel_err_d;
        end
    end

    always_comb begin
        digit_tick  = (div_cnt_q == DIV_LAST);
        frame_tick  = digit_tick && (which_q == DIG_LAST);
        div_cnt_d   = digit_tick ? '0 : div_cnt_q + 1'b1;
        which_d     = which_q;
        if (digit_tick) which_d = frame_tick ? '0 : which_q + 1'b1;

        sel_oor     = ({1'b0, sel} >= 5'(NCH));
        sel_err_d   = sel_oor;
        mode_d      = auto_en ? MODE_AUTO : MODE_MANUAL;
        next_ch     = cur_ch_q;
        frame_cnt_d = frame_cnt_q;

        // the incoming mode decides next_ch so a coinciding frame_tick already obeys it
        case (mode_d)
            MODE_MANUAL: begin
                next_ch     = sel_oor ? '0 : sel;
                frame_cnt_d = '0;
            end
            MODE_AUTO: begin
                if (mode_q == MODE_MANUAL) begin
                    frame_cnt_d = '0;
                end else if (frame_tick && !freeze) begin
                    if (frame_cnt_q == DWELL_LAST) begin
                        frame_cnt_d = '0;
                        next_ch     = (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: next_ch = cur_ch_q;
        endcase

        cur_ch_d = cur_ch_q;
        snap_d   = snap_q;
        if (frame_tick && !freeze) begin
            cur_ch_d = next_ch;
            snap_d   = ch_data[next_ch];
        end
    end

`ifdef DEBUG_PROBE_ZERO_BLANK_EN
    logic [DW-1:0] snap_shift;
    always_comb begin
        snap_shift = snap_q >> {which_q, 2'b00};
        nibble     = snap_shift[3:0];
        // a digit is a leading zero when it and everything above it is zero
        blank      = (which_q != '0) && (snap_shift == '0);
    end
`else
    always_comb begin
        nibble = 4'(snap_q >> {which_q, 2'b00});
        blank  = 1'b0;
    end
`endif

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (nibble),
        .glyph_o  (glyph)
    );

    always_comb begin
        dp  = (freeze && (which_q == DIG_LAST)) || ((mode_q == MODE_AUTO) && (which_q == '0));
        seg = {dp, blank ? SEG_BLANK : glyph};
    end

    assign cur_ch  = cur_ch_q;
    assign sel_err = sel_err_q;
    assign which   = which_q;

endmodule

// File: tb/tb_debug_probe_display.sv
// Bench for debug_probe_display: scoreboard of per-digit glyphs per frame plus
// direct checks of channel selection, auto-scan, freeze and reset behaviour.
module tb_debug_probe_display;

    localparam int DW = 32;
    localparam logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, auto_en, freeze, churn;
    logic [3:0]        sel;
    logic [16*DW-1:0]  base16, noise16, probe16;
    logic [10*DW-1:0]  probe10;
    logic [3:0]        cur16, which16, cur10, which10;
    logic              err16, err10;
    logic [7:0]        seg16, seg10;

    assign probe16 = base16 ^ noise16;

    always @(negedge clk) noise16 = churn ? {16{$urandom}} : '0;

    debug_probe_display #(.NCH(16), .DW(DW), .DIGITS(8), .REFRESH_DIV(4), .DWELL_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .probe_bus(probe16), .sel(sel), .auto_en(auto_en), .freeze(freeze),
        .cur_ch(cur16), .sel_err(err16), .which(which16), .seg(seg16));

    debug_probe_display #(.NCH(10), .DW(DW), .DIGITS(8), .REFRESH_DIV(4), .DWELL_FRAMES(2)) dut10 (
        .clk(clk), .rst(rst), .probe_bus(probe10), .sel(sel), .auto_en(auto_en), .freeze(freeze),
        .cur_ch(cur10), .sel_err(err10), .which(which10), .seg(seg10));

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] sb_q [$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ch16(int k);
        return base16[k*DW +: DW];
    endfunction

    function automatic logic [31:0] ch10(int k);
        return probe10[k*DW +: DW];
    endfunction

    function automatic logic [7:0] exp_seg(logic [31:0] v, int d, bit frz, bit au);
        logic [31:0] sh;
        logic [6:0]  g;
        sh = v >> (4*d);
        g  = GLY[sh[3:0]];
`ifdef DEBUG_PROBE_ZERO_BLANK_EN
        if (d != 0 && sh == 0) g = 7'h00;
`endif
        return {(frz && d == 7) || (au && d == 0), g};
    endfunction

    // Starts #1 after a frame edge, ends #1 after the next one.
    task automatic run_frame(string tag, logic [31:0] v, bit collide);
        logic [11:0] e;
        for (int d = 0; d < 8; d++) sb_q.push_back({4'(d), exp_seg(v, d, freeze, auto_en)});
        for (int d = 0; d < 8; d++) begin
            repeat (2) @(posedge clk);
            #1;
            e = sb_q.pop_front();
            chk($sformatf("%s/which%0d", tag, d), {28'd0, which16}, {28'd0, e[11:8]});
            chk($sformatf("%s/seg%0d", tag, d), {24'd0, seg16}, {24'd0, e[7:0]});
            if (d == 7 && collide) begin
                @(posedge clk); #1 freeze = 1'b1;
                @(posedge clk); #1 freeze = 1'b0;
            end else begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        churn = 1'b0; rst = 1'b0; auto_en = 1'b0; freeze = 1'b0; sel = 4'd3;
        for (int k = 0; k < 16; k++) base16[k*DW +: DW] = 32'h9E37_79B9 * (k + 1);
        base16[3*DW +: DW] = 32'h1234_ABCD;
        base16[6*DW +: DW] = 32'h0000_00A5;
        for (int k = 0; k < 10; k++) probe10[k*DW +: DW] = 32'hC0DE_0000 | (k * 32'h111);

        repeat (2) @(posedge clk);
        #1;
        chk("rst/which", {28'd0, which16}, 0);
        chk("rst/seg", {24'd0, seg16}, 32'h3F);
        chk("rst/cur_ch", {28'd0, cur16}, 0);
        chk("rst/sel_err", {31'd0, err10}, 0);
        rst = 1'b1;

        run_frame("m0", 32'h0, 1'b0);
        chk("m0/cur_ch", {28'd0, cur16}, 3);
        sel = 4'd14;
        run_frame("m1", ch16(3), 1'b0);
        chk("m1/cur_ch", {28'd0, cur16}, 14);

        auto_en = 1'b1;
        run_frame("a0", ch16(14), 1'b0);
        chk("a0/cur_ch", {28'd0, cur16}, 14);
        run_frame("a1", ch16(14), 1'b0);
        chk("a1/cur_ch", {28'd0, cur16}, 15);
        run_frame("a2", ch16(15), 1'b0);
        chk("a2/cur_ch", {28'd0, cur16}, 15);
        run_frame("a3", ch16(15), 1'b0);
        chk("a3/cur_ch", {28'd0, cur16}, 0);

        freeze = 1'b1; churn = 1'b1;
        for (int f = 0; f < 10; f++) begin
            run_frame($sformatf("frz%0d", f), ch16(0), 1'b0);
            chk($sformatf("frz%0d/cur_ch", f), {28'd0, cur16}, 0);
        end
        freeze = 1'b0; churn = 1'b0;
        run_frame("rel0", ch16(0), 1'b0);
        chk("rel0/cur_ch", {28'd0, cur16}, 0);
        run_frame("rel1", ch16(0), 1'b0);
        chk("rel1/cur_ch", {28'd0, cur16}, 1);

        auto_en = 1'b0; sel = 4'd3;
        run_frame("back", ch16(1), 1'b0);
        chk("back/cur_ch", {28'd0, cur16}, 3);
        sel = 4'd5;
        run_frame("coll", ch16(3), 1'b1);
        chk("coll/cur_ch", {28'd0, cur16}, 3);

        repeat (22) @(posedge clk);
        #1;
        chk("mid/which", {28'd0, which16}, 5);
        chk("mid/seg", {24'd0, seg16}, {24'd0, exp_seg(ch16(3), 5, 1'b0, 1'b0)});
        sel = 4'd6; rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst2/which", {28'd0, which16}, 0);
        chk("rst2/seg", {24'd0, seg16}, 32'h3F);
        chk("rst2/cur_ch", {28'd0, cur16}, 0);
        rst = 1'b1;

        run_frame("z0", 32'h0, 1'b0);
        chk("z0/cur_ch", {28'd0, cur16}, 6);
        sel = 4'd12;
        run_frame("z1", ch16(6), 1'b0);
        chk("oor/cur_ch16", {28'd0, cur16}, 12);
        chk("oor/cur_ch10", {28'd0, cur10}, 0);
        chk("oor/sel_err10", {31'd0, err10}, 1);
        chk("oor/sel_err16", {31'd0, err16}, 0);
        sel = 4'd5;
        run_frame("s5", ch16(12), 1'b0);
        chk("s5/cur_ch10", {28'd0, cur10}, 5);
        chk("s5/sel_err10", {31'd0, err10}, 0);
        chk("s5/cur_ch16", {28'd0, cur16}, 5);

        repeat (2) @(posedge clk);
        #1;
        chk("n10/which0", {28'd0, which10}, 0);
        chk("n10/seg0", {24'd0, seg10}, {24'd0, exp_seg(ch10(5), 0, 1'b0, 1'b0)});
        repeat (4) @(posedge clk);
        #1;
        chk("n10/which1", {28'd0, which10}, 1);
        chk("n10/seg1", {24'd0, seg10}, {24'd0, exp_seg(ch10(5), 1, 1'b0, 1'b0)});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
